// File: rtl/netwalk_dpl_pkg.sv
// ----------------------------------------------------------------------------
// netwalk_dpl_pkg
// Shared constants for the netwalk dataplane miss-packet path:
//   - header width, controller word width and words per header
//   - magic byte that opens the optional sequence word
//   - serialiser FSM state encoding
// No ports (package).
// ----------------------------------------------------------------------------
package netwalk_dpl_pkg;

    localparam int DPL_PKT_BIT_WIDTH = 608;
    localparam int CTRL_WORD_WIDTH   = 32;
    localparam int NWORDS            = DPL_PKT_BIT_WIDTH / CTRL_WORD_WIDTH;

    localparam logic [7:0] SEQ_MAGIC = 8'hA5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/netwalk_miss_fifo.sv
// ----------------------------------------------------------------------------
// netwalk_miss_fifo
// Synchronous FIFO of WIDTH-bit entries, depth 2**AW.
// Full/empty come from the occupancy counter; pointers wrap modulo depth.
// A push while full is taken only if a pop happens in the same cycle (the
// popped slot is the one being written). No drop accounting here.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   push, push_data   write request and data
//   pop               remove head entry
//   head_data         entry at the read pointer
//   count             occupied entries (registered)
//   full, empty       occupancy flags derived from count
// ----------------------------------------------------------------------------
module netwalk_miss_fifo #(
    parameter int WIDTH = 608,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Qualify requests and compute next pointer / occupancy values.
    always_comb begin
        pop_ok_s  = pop & ~empty;
        push_ok_s = push & (~full | pop_ok_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care after reset since count is 0.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/netwalk_miss_pkt_queue.sv
// ----------------------------------------------------------------------------
// netwalk_miss_pkt_queue
// Buffers table-miss headers from the dataplane core and serialises each one
// MSB-first as CTRL_WORD_WIDTH-bit words on a valid/ready packet-in port.
// Misses arriving while the FIFO is full are dropped and counted, so the
// dataplane never stalls. One idle cycle separates consecutive headers.
// Optional build macro MISS_PKT_SEQ_HDR_EN: each header is preceded by a word
// {8'hA5, 8'h00, seq[15:0]}, seq counting popped headers.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   missed_pkt_en       strobe qualifying handler_pkt_header
//   handler_pkt_header  missed header
//   ctrl_data/valid/ready/sop/eop  packet-in word stream (registered)
//   miss_fifo_count     occupied FIFO entries, including the one being sent
//   miss_drop_count     saturating count of dropped headers
// ----------------------------------------------------------------------------
module netwalk_miss_pkt_queue
    import netwalk_dpl_pkg::*;
#(
    parameter int DPL_PKT_BIT_WIDTH    = 608,
    parameter int CTRL_WORD_WIDTH      = 32,
    parameter int MISS_FIFO_ADDR_WIDTH = 2,
    parameter int DROP_CNT_WIDTH       = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           missed_pkt_en,
    input  logic [DPL_PKT_BIT_WIDTH-1:0]   handler_pkt_header,
    output logic [CTRL_WORD_WIDTH-1:0]     ctrl_data,
    output logic                           ctrl_valid,
    input  logic                           ctrl_ready,
    output logic                           ctrl_sop,
    output logic                           ctrl_eop,
    output logic [MISS_FIFO_ADDR_WIDTH:0]  miss_fifo_count,
    output logic [DROP_CNT_WIDTH-1:0]      miss_drop_count
);

    localparam int N_WORDS = DPL_PKT_BIT_WIDTH / CTRL_WORD_WIDTH;
`ifdef MISS_PKT_SEQ_HDR_EN
    localparam int HDR_WORDS = N_WORDS + 1;
`else
    localparam int HDR_WORDS = N_WORDS;
`endif
    localparam int IDX_W = $clog2(HDR_WORDS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_WORDS - 1);

    // Word k of a header: shift it to the top, then take the top word.
    function automatic logic [CTRL_WORD_WIDTH-1:0] hdr_word(
        input logic [DPL_PKT_BIT_WIDTH-1:0] hdr,
        input logic [IDX_W-1:0]             k
    );
        logic [DPL_PKT_BIT_WIDTH-1:0] sh;
        sh = hdr << (int'(k) * CTRL_WORD_WIDTH);
        return sh[DPL_PKT_BIT_WIDTH-1 -: CTRL_WORD_WIDTH];
    endfunction

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [CTRL_WORD_WIDTH-1:0]      ctrl_data_q, ctrl_data_d;
    logic                            ctrl_valid_q, ctrl_valid_d;
    logic                            ctrl_sop_q, ctrl_sop_d;
    logic                            ctrl_eop_q, ctrl_eop_d;
    logic [DROP_CNT_WIDTH-1:0]       drop_cnt_q, drop_cnt_d;
`ifdef MISS_PKT_SEQ_HDR_EN
    logic [15:0]                     seq_q, seq_d;
`endif

    logic                            push_s;
    logic                            pop_s;
    logic                            handshake_s;
    logic [IDX_W-1:0]                load_idx_s;
    logic [CTRL_WORD_WIDTH-1:0]      load_word_s;
    logic [DPL_PKT_BIT_WIDTH-1:0]    head_s;
    logic                            fifo_full_s;
    logic                            fifo_empty_s;

    netwalk_miss_fifo #(
        .WIDTH (DPL_PKT_BIT_WIDTH),
        .AW    (MISS_FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (handler_pkt_header),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (miss_fifo_count),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign handshake_s     = ctrl_valid_q & ctrl_ready;
    assign ctrl_data       = ctrl_data_q;
    assign ctrl_valid      = ctrl_valid_q;
    assign ctrl_sop        = ctrl_sop_q;
    assign ctrl_eop        = ctrl_eop_q;
    assign miss_drop_count = drop_cnt_q;

    // Select the word to register next: position 0 from IDLE, else idx+1.
    always_comb begin
        if (state_q == ST_IDLE) begin
            load_idx_s = '0;
        end else begin
            load_idx_s = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
`ifdef MISS_PKT_SEQ_HDR_EN
        if (load_idx_s == '0) begin
            load_word_s = CTRL_WORD_WIDTH'({SEQ_MAGIC, 8'h00, seq_q});
        end else begin
            load_word_s = hdr_word(head_s, load_idx_s - {{(IDX_W-1){1'b0}}, 1'b1});
        end
`else
        load_word_s = hdr_word(head_s, load_idx_s);
`endif
    end

    // Serialiser next-state, pop/push qualification and drop counting.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ctrl_data_d  = ctrl_data_q;
        ctrl_valid_d = ctrl_valid_q;
        ctrl_sop_d   = ctrl_sop_q;
        ctrl_eop_d   = ctrl_eop_q;
        pop_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_d      = ST_SEND;
                    idx_d        = '0;
                    ctrl_data_d  = load_word_s;
                    ctrl_valid_d = 1'b1;
                    ctrl_sop_d   = 1'b1;
                    ctrl_eop_d   = (LAST_IDX == '0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (handshake_s) begin
                    if (ctrl_eop_q) begin
                        // Header done: release the entry; IDLE reloads next cycle.
                        pop_s        = 1'b1;
                        state_d      = ST_IDLE;
                        idx_d        = '0;
                        ctrl_valid_d = 1'b0;
                        ctrl_sop_d   = 1'b0;
                        ctrl_eop_d   = 1'b0;
                    end else begin
                        idx_d       = load_idx_s;
                        ctrl_data_d = load_word_s;
                        ctrl_sop_d  = 1'b0;
                        ctrl_eop_d  = (load_idx_s == LAST_IDX);
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                idx_d        = '0;
                ctrl_valid_d = 1'b0;
                ctrl_sop_d   = 1'b0;
                ctrl_eop_d   = 1'b0;
            end
        endcase

        // A full FIFO still takes a miss when the head leaves this cycle.
        push_s = missed_pkt_en & (~fifo_full_s | pop_s);
        if (missed_pkt_en && !push_s && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
`ifdef MISS_PKT_SEQ_HDR_EN
        if (pop_s) begin
            seq_d = seq_q + 16'd1;
        end else begin
            seq_d = seq_q;
        end
`endif
    end

    // Serialiser state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            ctrl_data_q  <= '0;
            ctrl_valid_q <= 1'b0;
            ctrl_sop_q   <= 1'b0;
            ctrl_eop_q   <= 1'b0;
            drop_cnt_q   <= '0;
`ifdef MISS_PKT_SEQ_HDR_EN
            seq_q        <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ctrl_data_q  <= ctrl_data_d;
            ctrl_valid_q <= ctrl_valid_d;
            ctrl_sop_q   <= ctrl_sop_d;
            ctrl_eop_q   <= ctrl_eop_d;
            drop_cnt_q   <= drop_cnt_d;
`ifdef MISS_PKT_SEQ_HDR_EN
            seq_q        <= seq_d;
`endif
        end
    end

endmodule

// File: tb/tb_netwalk_miss_pkt_queue.sv
// ----------------------------------------------------------------------------
// tb_netwalk_miss_pkt_queue
// Directed bench for netwalk_miss_pkt_queue: reset, single miss, backpressure,
// overflow/drop, full-with-pop, reset mid-header and the optional sequence word.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_netwalk_miss_pkt_queue;

    localparam int W  = 608;
    localparam int CW = 32;
    localparam int NW = 19;
`ifdef MISS_PKT_SEQ_HDR_EN
    localparam int HW = NW + 1;
`else
    localparam int HW = NW;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [W-1:0]  hdr;
    logic [CW-1:0] ctrl_data;
    logic          ctrl_valid;
    logic          ready;
    logic          ctrl_sop;
    logic          ctrl_eop;
    logic [2:0]    fifo_count;
    logic [15:0]   drop_count;

    int checks  = 0;
    int errors  = 0;
    int exp_seq = 0;

    netwalk_miss_pkt_queue dut (
        .clk                (clk),
        .reset              (rst),
        .missed_pkt_en      (en),
        .handler_pkt_header (hdr),
        .ctrl_data          (ctrl_data),
        .ctrl_valid         (ctrl_valid),
        .ctrl_ready         (ready),
        .ctrl_sop           (ctrl_sop),
        .ctrl_eop           (ctrl_eop),
        .miss_fifo_count    (fifo_count),
        .miss_drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    // Header word k for a given tag; tag 0 is the hand-written single-miss header.
    function automatic logic [CW-1:0] exp_word(input int tag, input int k);
        if (tag == 0) begin
            if (k == 0)       return 32'h0000_0072;
            else if (k == 18) return 32'hFFFF_06A5;
            else              return 32'hFFFF_FFFF;
        end
        return {tag[7:0], k[7:0], 16'hBEEF};
    endfunction

    function automatic logic [W-1:0] make_hdr(input int tag);
        logic [W-1:0] h;
        h = '0;
        for (int k = 0; k < NW; k++) h = (h << CW) | W'(exp_word(tag, k));
        return h;
    endfunction

    // Expected word at stream position k of a header.
    function automatic logic [CW-1:0] pos_word(input int tag, input int k);
`ifdef MISS_PKT_SEQ_HDR_EN
        logic [31:0] s;
        s = exp_seq;
        if (k == 0) return {8'hA5, 8'h00, s[15:0]};
        return exp_word(tag, k - 1);
`else
        return exp_word(tag, k);
`endif
    endfunction

    // Push one header and check the two-cycle latency to word 0.
    task automatic push_and_latency(input int tag);
        logic [CW-1:0] w0;
        w0 = pos_word(tag, 0);
        hdr = make_hdr(tag);
        en  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (fifo_count !== 3'd1 || ctrl_valid !== 1'b0) begin
            errors++;
            $display("FAIL push_n1 tag=%0d: count=%0d valid=%b, required count=1 valid=0", tag, fifo_count, ctrl_valid);
        end
        @(negedge clk);
        checks++;
        if (ctrl_valid !== 1'b1 || ctrl_sop !== 1'b1 || ctrl_data !== w0) begin
            errors++;
            $display("FAIL push_n2 tag=%0d: valid=%b sop=%b data=%h, required 1 1 %h", tag, ctrl_valid, ctrl_sop, ctrl_data, w0);
        end
    endtask

    // Accept up to nmax words of header 'tag'; optionally toggle ready and
    // push header push_tag on the eop handshake cycle (push_tag<0: none).
    task automatic recv_hdr(input int tag, input int nmax, input bit toggle, input int push_tag);
        int            k   = 0;
        int            cyc = 0;
        bit            hold_chk = 1'b0;
        logic [CW-1:0] held = '0;
        logic [CW-1:0] exp;
        while (k < nmax && cyc < 200) begin
            if (hold_chk) begin
                checks++;
                if (ctrl_valid !== 1'b1 || ctrl_data !== held) begin
                    errors++;
                    $display("FAIL hold tag=%0d: valid=%b data=%h, required valid=1 data=%h", tag, ctrl_valid, ctrl_data, held);
                end
            end
            en    = 1'b0;
            ready = toggle ? cyc[0] : 1'b1;
            if (ctrl_valid === 1'b1 && ready === 1'b1) begin
                exp = pos_word(tag, k);
                checks++;
                if (ctrl_data !== exp || ctrl_sop !== (k == 0) || ctrl_eop !== (k == HW - 1)) begin
                    errors++;
                    $display("FAIL word tag=%0d k=%0d: data=%h sop=%b eop=%b, required %h %b %b",
                             tag, k, ctrl_data, ctrl_sop, ctrl_eop, exp, (k == 0), (k == HW - 1));
                end
                if (k == HW - 1) begin
                    exp_seq++;
                    if (push_tag >= 0) begin
                        hdr = make_hdr(push_tag);
                        en  = 1'b1;
                    end
                end
                k++;
                hold_chk = 1'b0;
            end else if (ctrl_valid === 1'b1) begin
                held     = ctrl_data;
                hold_chk = 1'b1;
            end else begin
                hold_chk = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        en = 1'b0;
        checks++;
        if (k < nmax) begin
            errors++;
            $display("FAIL recv_timeout tag=%0d: got %0d words, required %0d", tag, k, nmax);
        end
    endtask

    task automatic check_counts(input string nm, input int cnt, input int drops);
        checks++;
        if (fifo_count !== 3'(cnt) || drop_count !== 16'(drops)) begin
            errors++;
            $display("FAIL %s: count=%0d drops=%0d, required count=%0d drops=%0d", nm, fifo_count, drop_count, cnt, drops);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; ready = 1'b0; hdr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl_valid !== 1'b0 || ctrl_sop !== 1'b0 || ctrl_eop !== 1'b0 || ctrl_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: valid=%b sop=%b eop=%b data=%h, required all 0", ctrl_valid, ctrl_sop, ctrl_eop, ctrl_data);
        end
        check_counts("reset_cnt", 0, 0);
    endtask

    task automatic test_single();
        ready = 1'b1;
        push_and_latency(0);
        recv_hdr(0, HW, 1'b0, -1);
        checks++;
        if (ctrl_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_bubble: valid=%b, required 0", ctrl_valid);
        end
        check_counts("single_cnt", 0, 0);
    endtask

    task automatic test_backpressure();
        ready = 1'b1;
        push_and_latency(1);
        recv_hdr(1, HW, 1'b1, -1);
        check_counts("bp_cnt", 0, 0);
    endtask

    task automatic test_overflow();
        ready = 1'b0;
        for (int t = 2; t < 8; t++) begin
            hdr = make_hdr(t);
            en  = 1'b1;
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
        check_counts("ovf_cnt", 4, 2);
        for (int t = 2; t < 6; t++) recv_hdr(t, HW, 1'b0, -1);
        check_counts("ovf_drain", 0, 2);
    endtask

    task automatic test_full_pop();
        ready = 1'b0;
        for (int t = 8; t < 12; t++) begin
            hdr = make_hdr(t);
            en  = 1'b1;
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
        check_counts("full_cnt", 4, 2);
        recv_hdr(8, HW, 1'b0, 12);
        check_counts("full_pop", 4, 2);
        for (int t = 9; t < 13; t++) recv_hdr(t, HW, 1'b0, -1);
        check_counts("full_drain", 0, 2);
    endtask

    task automatic test_reset_mid();
        ready = 1'b1;
        push_and_latency(13);
        recv_hdr(13, 8, 1'b0, -1);
        ready = 1'b0;
        rst   = 1'b1;
        #1;
        checks++;
        if (ctrl_valid !== 1'b0 || ctrl_sop !== 1'b0 || ctrl_eop !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_out: valid=%b sop=%b eop=%b, required 0 0 0", ctrl_valid, ctrl_sop, ctrl_eop);
        end
        check_counts("rst_mid_cnt", 0, 0);
        @(negedge clk);
        rst     = 1'b0;
        exp_seq = 0;
        @(negedge clk);
        ready = 1'b1;
        push_and_latency(14);
        recv_hdr(14, HW, 1'b0, -1);
        check_counts("rst_mid_after", 0, 0);
    endtask

`ifdef MISS_PKT_SEQ_HDR_EN
    task automatic test_seq_hdr();
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        exp_seq = 0;
        ready   = 1'b0;
        for (int t = 20; t < 22; t++) begin
            hdr = make_hdr(t);
            en  = 1'b1;
            @(negedge clk);
        end
        en = 1'b0;
        checks++;
        if (ctrl_valid !== 1'b1 || ctrl_data !== 32'hA500_0000 || ctrl_sop !== 1'b1) begin
            errors++;
            $display("FAIL seq_first: valid=%b data=%h sop=%b, required 1 a5000000 1", ctrl_valid, ctrl_data, ctrl_sop);
        end
        recv_hdr(20, HW, 1'b0, -1);
        @(negedge clk);
        checks++;
        if (ctrl_valid !== 1'b1 || ctrl_data !== 32'hA500_0001 || ctrl_sop !== 1'b1) begin
            errors++;
            $display("FAIL seq_second: valid=%b data=%h sop=%b, required 1 a5000001 1", ctrl_valid, ctrl_data, ctrl_sop);
        end
        recv_hdr(21, HW, 1'b0, -1);
        check_counts("seq_drain", 0, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_reset_mid();
`ifdef MISS_PKT_SEQ_HDR_EN
        test_seq_hdr();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/netwalk_miss_pkt_queue.md
Name: netwalk_miss_pkt_queue

Overview:
Downstream stage of netwalk_dataplane_core.
- Captures table-miss packet headers (handler_pkt_header, qualified by missed_pkt_en) into a small FIFO.
- Serialises each header MSB-first as 32-bit words to the controller packet-in interface over a valid/ready handshake.
- Counts headers dropped because the FIFO was full, so the dataplane never stalls on misses.

Parameters:
- DPL_PKT_BIT_WIDTH, 608, header width; must be a multiple of CTRL_WORD_WIDTH.
- CTRL_WORD_WIDTH, 32, output word width.
- MISS_FIFO_ADDR_WIDTH, 2, FIFO depth = 2**MISS_FIFO_ADDR_WIDTH (default 4 entries).
- DROP_CNT_WIDTH, 16, drop counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- missed_pkt_en  in  1  one-cycle strobe: handler_pkt_header holds a missed header.
- handler_pkt_header  in  DPL_PKT_BIT_WIDTH  missed header from the core.
- ctrl_data  out  CTRL_WORD_WIDTH  current output word.
- ctrl_valid  out  1  ctrl_data is valid.
- ctrl_ready  in  1  controller accepts the word this cycle.
- ctrl_sop  out  1  first word of a header.
- ctrl_eop  out  1  last word of a header.
- miss_fifo_count  out  MISS_FIFO_ADDR_WIDTH+1  occupied entries, including the one being sent.
- miss_drop_count  out  DROP_CNT_WIDTH  saturating count of dropped headers.

Behaviour:
- Reset (async assert, sync release):
  - ctrl_valid, ctrl_sop, ctrl_eop, ctrl_data = 0.
  - miss_fifo_count = 0, miss_drop_count = 0.
  - FIFO pointers = 0; FSM = IDLE; word index = 0.
- Push:
  - Accepted when missed_pkt_en=1 and (count < DEPTH, or the eop word is handshaked this cycle).
  - Otherwise the header is discarded and miss_drop_count increments, saturating at all-ones.
- Word sequencing:
  - NWORDS = DPL_PKT_BIT_WIDTH/CTRL_WORD_WIDTH (19 by default).
  - Word k = header bits [W-1-32k -: 32], i.e. word 0 is bits 607:576.
- FSM states: IDLE, SEND.
  - IDLE -> SEND when FIFO is non-empty. Loads word 0 of the head entry into ctrl_data, sets ctrl_valid=1 and ctrl_sop=1, and sets ctrl_eop=1 only if NWORDS==1.
  - SEND, handshake (ctrl_valid & ctrl_ready) on a non-last word: advance the word index and register the next word next cycle; sop=0; eop=1 on the final word.
  - SEND, handshake on the eop word: pop the head entry and clear ctrl_valid.
    - If another entry is present after the pop (including a same-cycle push into an empty-after-pop FIFO), go to IDLE, then reload next cycle.
    - One idle bubble between headers is required and intended.
  - SEND without ready: ctrl_data, sop, eop and valid are held stable.
- Latency: push at cycle N into an empty FIFO with FSM in IDLE gives ctrl_valid=1 with word 0 at cycle N+2; with N+1 = IDLE sees non-empty.
- Counting:
  - miss_fifo_count updates one cycle after the push or pop.
  - Simultaneous push and pop leaves the count unchanged.
- Pointers wrap modulo DEPTH; full/empty are taken from the count, not from pointer compare.
- Reset mid-header: the header is abandoned with no partial eop; the FIFO contents are lost.

Optional Feature:
- Macro MISS_PKT_SEQ_HDR_EN.
- When defined, each header is preceded by one extra word {8'hA5, 8'h00, seq[15:0]}:
  - sop is on the extra word, and header word 0 has sop=0.
  - seq is a 16-bit counter, reset 0, incremented on each pop, wrapping at 16'hFFFF -> 0.
  - Each header is NWORDS+1 words.
- When undefined: no sequence counter and exactly NWORDS words per header.

Decomposition:
- Package netwalk_dpl_pkg holds:
  - DPL_PKT_BIT_WIDTH, CTRL_WORD_WIDTH, NWORDS.
  - The magic byte 8'hA5.
  - The FSM state encoding (IDLE=0, SEND=1).
- Sub-module netwalk_miss_fifo: synchronous FIFO of DPL_PKT_BIT_WIDTH-wide entries with push, pop, head data, count, full and empty. It has no drop logic.
- Serialiser FSM and drop counter live in the top module.

Test Plan:
1. Single miss: push header 608'h0000_0072_FFFF…_06A5 with ctrl_ready=1 held. Expect 19 words starting at N+2:
   - word 0 = 32'h00000072, word 18 = low 32 bits;
   - sop on word 0 only, eop on word 18;
   - count 1 -> 0.
2. Backpressure: toggle ctrl_ready 1/0 every cycle. Expect ctrl_data stable whenever valid & !ready, the same 19 words in order, and no duplicates.
3. Overflow: ctrl_ready=0, push 6 headers on consecutive cycles. Expect count=4, miss_drop_count=2; after releasing ready, the first 4 headers come out in FIFO order.
4. Full plus simultaneous pop: FIFO full, push on the eop-handshake cycle. Expect the push accepted, count stays 4, and drop count unchanged.
5. Reset mid-header: assert reset after word 7. Expect ctrl_valid=0 immediately (async) and all counters 0; a new push after release starts at word 0 with sop.
6. With MISS_PKT_SEQ_HDR_EN: push two headers. Expect first words 32'hA5000000 and 32'hA5000001, each header 20 words long, and sop only on the A5 word.
